// File: rtl/apb3_completer_regs.sv
// APB3 completer register bank: constant ID word, completed-transfer counter and
// read/write scratch words, with a fixed number of wait states per access and
// PSLVERR for out-of-window, misaligned or read-only-target accesses.
//
// Handshake: a transfer is latched on the edge that sees psel=1, penable=0
// (setup). It completes on the edge that sees psel=1, penable=1, pready=1.
// pready, prdata and pslverr are registered. prdata and pslverr are only
// meaningful while pready=1. Dropping psel before completion abandons the
// transfer without side effects.
module apb3_completer_regs #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_REGS    = 16,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA5B3_0001
) (
  input  logic                         pclk,
  input  logic                         prst_n,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  output logic                         pready,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

  localparam int         IDX_W     = ADDR_W - 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic       NO_WAIT   = (WAIT_CYCLES == 0);

  // SETUP: request latched, first access cycle under way.
  // ACCESS: later access cycles (wait states or completion).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] xfer_cnt;
  logic [DATA_W-1:0] scratch [2:NUM_REGS-1];
  logic [DATA_W-1:0] words   [NUM_REGS];

  logic              busy;
  logic              setup_req;
  logic              start;
  logic              complete;
  logic              abort;
  logic              step;

  logic [ADDR_W-1:0] sel_addr;
  logic              sel_write;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  commit_idx;
  logic [DATA_W-1:0] rd_word;
  logic              resp_err;
  logic              resp_load;
  logic [DATA_W-1:0] resp_data;

  // Bus phase decode.
  always_comb begin
    busy      = (state_q != IDLE);
    setup_req = psel && !penable;
    start     = setup_req;
    complete  = busy && psel && penable && pready;
    abort     = busy && !psel;
    step      = busy && psel && penable && !pready;
  end

  // Response is computed from the live bus in IDLE (zero-wait case) and from
  // the latched request once a transfer is in flight.
  always_comb begin
    sel_addr   = busy ? addr_q : paddr;
    sel_write  = busy ? write_q : pwrite;
    sel_idx    = sel_addr[ADDR_W-1:2];
    commit_idx = addr_q[ADDR_W-1:2];
    resp_err   = (sel_idx >= IDX_W'(NUM_REGS)) ||
                 (sel_addr[1:0] != 2'b00) ||
                 (sel_write && (sel_idx < IDX_W'(2)));
    resp_load  = resp_err || !sel_write;
    resp_data  = resp_err ? '0 : rd_word;
  end

  // Flat word view of the register map.
  always_comb begin
    words[0] = ID_VALUE;
    words[1] = xfer_cnt;
    for (int i = 2; i < NUM_REGS; i++) begin
      words[i] = scratch[i];
    end
  end

  // Read multiplexer over the register map.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        rd_word = words[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_W +: DATA_W] = words[g];
  end

  // FSM state register.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a new setup always (re)starts, psel low abandons,
  // completion returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (setup_req) state_d = SETUP;
      end
      SETUP, ACCESS: begin
        if (!psel)         state_d = IDLE;
        else if (!penable) state_d = SETUP;
        else if (pready)   state_d = IDLE;
        else               state_d = ACCESS;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, wait counter and registered response.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
    end else if (start) begin
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
      cnt_q   <= WAIT_INIT;
      pready  <= NO_WAIT;
      if (NO_WAIT) begin
        pslverr <= resp_err;
        if (resp_load) prdata <= resp_data;
      end else begin
        pslverr <= 1'b0;
      end
    end else if (complete || abort) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else if (step) begin
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        pready  <= 1'b1;
        pslverr <= resp_err;
        if (resp_load) prdata <= resp_data;
      end
    end
  end

  // Register file: commit writes and count transfers only on OKAY completion.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      xfer_cnt <= '0;
      for (int i = 2; i < NUM_REGS; i++) begin
        scratch[i] <= '0;
      end
    end else if (complete && !pslverr) begin
      xfer_cnt <= xfer_cnt + 1'b1;
      if (write_q) begin
        for (int i = 2; i < NUM_REGS; i++) begin
          if (commit_idx == IDX_W'(i)) scratch[i] <= wdata_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb3_completer_regs.sv
// Bench for apb3_completer_regs: two instances (zero and three wait states) on
// separate buses, a word-level model of the register map, scenario tasks with
// inline checks and a randomized mixed-traffic run.
module tb_apb3_completer_regs;

  localparam int          NR = 16;
  localparam logic [31:0] ID = 32'hA5B3_0001;

  logic pclk = 1'b0;
  logic prst_n = 1'b0;

  logic [1:0]              psel_v, penable_v, pwrite_v, pready_v, pslverr_v;
  logic [1:0][31:0]        paddr_v, pwdata_v, prdata_v;
  logic [1:0][NR*32-1:0]   regq_v;

  int n_tests = 0;
  int n_fail  = 0;

  int          wait_of [2] = '{0, 3};
  logic [31:0] m_regs  [2][NR];
  logic [31:0] m_cnt   [2];

  always #5 pclk = ~pclk;

  apb3_completer_regs #(.NUM_REGS(NR), .WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .prst_n(prst_n), .psel(psel_v[0]), .penable(penable_v[0]),
    .pwrite(pwrite_v[0]), .paddr(paddr_v[0]), .pwdata(pwdata_v[0]),
    .pready(pready_v[0]), .prdata(prdata_v[0]), .pslverr(pslverr_v[0]),
    .reg_q(regq_v[0])
  );

  apb3_completer_regs #(.NUM_REGS(NR), .WAIT_CYCLES(3)) dut1 (
    .pclk(pclk), .prst_n(prst_n), .psel(psel_v[1]), .penable(penable_v[1]),
    .pwrite(pwrite_v[1]), .paddr(paddr_v[1]), .pwdata(pwdata_v[1]),
    .pready(pready_v[1]), .prdata(prdata_v[1]), .pslverr(pslverr_v[1]),
    .reg_q(regq_v[1])
  );

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = '0;
      for (int i = 0; i < NR; i++) m_regs[d][i] = '0;
    end
  endfunction

  // One transfer at word level: error rules, read value, write effect, count.
  function automatic void model_xfer(input int d, input logic wr, input logic [31:0] a,
                                     input logic [31:0] wd, output logic [31:0] exp_rd,
                                     output logic exp_err);
    int idx;
    idx     = int'(a >> 2);
    exp_err = (idx >= NR) || (a[1:0] != 2'b00) || (wr && idx < 2);
    exp_rd  = '0;
    if (exp_err) return;
    if (!wr) begin
      if (idx == 0)      exp_rd = ID;
      else if (idx == 1) exp_rd = m_cnt[d];
      else               exp_rd = m_regs[d][idx];
    end else begin
      m_regs[d][idx] = wd;
    end
    m_cnt[d] = m_cnt[d] + 32'd1;
  endfunction

  function automatic logic [NR*32-1:0] exp_q(input int d);
    logic [NR*32-1:0] q;
    for (int i = 0; i < NR; i++) begin
      if (i == 0)      q[i*32 +: 32] = ID;
      else if (i == 1) q[i*32 +: 32] = m_cnt[d];
      else             q[i*32 +: 32] = m_regs[d][i];
    end
    return q;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    psel_v = '0; penable_v = '0; pwrite_v = '0; paddr_v = '0; pwdata_v = '0;
    prst_n = 1'b0;
    repeat (2) @(negedge pclk);
    prst_n = 1'b1;
    model_reset();
    @(negedge pclk);
  endtask

  // Starts at a negedge with the setup phase, ends at the negedge after the
  // completion edge with the bus released (caller may start the next one at once).
  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int waits,
                      output logic [NR*32-1:0] q_ready);
    psel_v[d] = 1'b1; penable_v[d] = 1'b0; pwrite_v[d] = wr; paddr_v[d] = a; pwdata_v[d] = wd;
    @(negedge pclk);
    penable_v[d] = 1'b1;
    waits = 0;
    while (pready_v[d] !== 1'b1 && waits < 40) begin
      @(negedge pclk);
      waits++;
    end
    if (pready_v[d] !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL xfer_timeout dut%0d addr=%h: pready still %b after 40 cycles, need 1", d, a, pready_v[d]);
    end
    rd = prdata_v[d]; err = pslverr_v[d]; q_ready = regq_v[d];
    @(negedge pclk);
    psel_v[d] = 1'b0; penable_v[d] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (pready_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_pready dut%0d got %b need 0", d, pready_v[d]); end
      n_tests++;
      if (prdata_v[d] !== 32'h0) begin n_fail++; $display("FAIL reset_prdata dut%0d got %h need 0", d, prdata_v[d]); end
      n_tests++;
      if (pslverr_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr dut%0d got %b need 0", d, pslverr_v[d]); end
      n_tests++;
      if (regq_v[d] !== exp_q(d)) begin n_fail++; $display("FAIL reset_reg_q dut%0d got %h need %h", d, regq_v[d], exp_q(d)); end
    end
  endtask

  task automatic test_id_and_count();
    logic [31:0] rd, e_rd; logic err, e_err; int w; logic [NR*32-1:0] q;
    logic [31:0] addrs [3];
    addrs = '{32'h4, 32'h0, 32'h4};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      model_xfer(0, 1'b0, addrs[k], 32'h0, e_rd, e_err);
      xfer(0, 1'b0, addrs[k], 32'h0, rd, err, w, q);
      n_tests++;
      if (rd !== e_rd) begin n_fail++; $display("FAIL id_cnt_rdata addr=%h got %h need %h", addrs[k], rd, e_rd); end
      n_tests++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL id_cnt_pslverr addr=%h got %b need 0", addrs[k], err); end
      n_tests++;
      if (w !== 0) begin n_fail++; $display("FAIL id_cnt_latency addr=%h wait=%0d need 0", addrs[k], w); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, e_rd; logic err, e_err; int w; logic [NR*32-1:0] q;
    do_reset();
    model_xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, e_rd, e_err);
    xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, rd, err, w, q);
    n_tests++;
    if (q[95:64] !== 32'h0) begin n_fail++; $display("FAIL b2b_before_commit got %h need 0", q[95:64]); end
    n_tests++;
    if (regq_v[0][95:64] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_after_commit got %h need deadbeef", regq_v[0][95:64]); end
    model_xfer(0, 1'b0, 32'h8, 32'h0, e_rd, e_err);
    xfer(0, 1'b0, 32'h8, 32'h0, rd, err, w, q);
    n_tests++;
    if (rd !== e_rd) begin n_fail++; $display("FAIL b2b_readback got %h need %h", rd, e_rd); end
    model_xfer(0, 1'b0, 32'h4, 32'h0, e_rd, e_err);
    xfer(0, 1'b0, 32'h4, 32'h0, rd, err, w, q);
    n_tests++;
    if (rd !== e_rd) begin n_fail++; $display("FAIL b2b_xfer_cnt got %h need %h", rd, e_rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, e_rd; logic err, e_err; int w; logic [NR*32-1:0] q;
    do_reset();
    model_xfer(1, 1'b1, 32'h8, 32'h1234_5678, e_rd, e_err);
    xfer(1, 1'b1, 32'h8, 32'h1234_5678, rd, err, w, q);
    n_tests++;
    if (w !== 3) begin n_fail++; $display("FAIL wait_write_cycles got %0d need 3", w); end
    model_xfer(1, 1'b0, 32'h8, 32'h0, e_rd, e_err);
    xfer(1, 1'b0, 32'h8, 32'h0, rd, err, w, q);
    n_tests++;
    if (w + 2 !== 5) begin n_fail++; $display("FAIL wait_read_span got %0d pclk need 5", w + 2); end
    n_tests++;
    if (rd !== e_rd) begin n_fail++; $display("FAIL wait_read_data got %h need %h", rd, e_rd); end
    n_tests++;
    if (pready_v[1] !== 1'b0) begin n_fail++; $display("FAIL wait_pready_drop got %b need 0", pready_v[1]); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, e_rd; logic err, e_err; int w; logic [NR*32-1:0] q;
    logic [31:0] addrs [5];
    logic        wrs   [5];
    addrs = '{32'h40, 32'h0, 32'h6, 32'h4, 32'h44};
    wrs   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int d = 0; d < 2; d++) begin
      model_xfer(d, 1'b0, 32'h0, 32'h0, e_rd, e_err);
      xfer(d, 1'b0, 32'h0, 32'h0, rd, err, w, q);
      for (int k = 0; k < 5; k++) begin
        model_xfer(d, wrs[k], addrs[k], 32'hFFFF_0000 + k, e_rd, e_err);
        xfer(d, wrs[k], addrs[k], 32'hFFFF_0000 + k, rd, err, w, q);
        n_tests++;
        if (err !== e_err) begin n_fail++; $display("FAIL err_pslverr dut%0d addr=%h got %b need %b", d, addrs[k], err, e_err); end
        if (!wrs[k]) begin
          n_tests++;
          if (rd !== e_rd) begin n_fail++; $display("FAIL err_prdata dut%0d addr=%h got %h need %h", d, addrs[k], rd, e_rd); end
        end
        n_tests++;
        if (regq_v[d] !== exp_q(d)) begin n_fail++; $display("FAIL err_reg_q dut%0d addr=%h got %h need %h", d, addrs[k], regq_v[d], exp_q(d)); end
      end
    end
  endtask

  task automatic test_cnt_wrap();
    logic [31:0] rd, e_rd; logic err, e_err; int w; logic [NR*32-1:0] q;
    do_reset();
    force dut0.xfer_cnt = 32'hFFFF_FFFF;
    #1;
    release dut0.xfer_cnt;
    m_cnt[0] = 32'hFFFF_FFFF;
    model_xfer(0, 1'b0, 32'h4, 32'h0, e_rd, e_err);
    xfer(0, 1'b0, 32'h4, 32'h0, rd, err, w, q);
    n_tests++;
    if (rd !== e_rd) begin n_fail++; $display("FAIL wrap_preload got %h need %h", rd, e_rd); end
    n_tests++;
    if (regq_v[0][63:32] !== m_cnt[0]) begin n_fail++; $display("FAIL wrap_count got %h need %h", regq_v[0][63:32], m_cnt[0]); end
  endtask

  task automatic test_protocol_abuse();
    logic [31:0] rd, e_rd; logic err, e_err; int w; logic [NR*32-1:0] q;
    do_reset();
    // penable without setup on the zero-wait instance
    psel_v[0] = 1'b1; penable_v[0] = 1'b1; paddr_v[0] = 32'h8; pwrite_v[0] = 1'b1; pwdata_v[0] = 32'h5555_AAAA;
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      n_tests++;
      if (pready_v[0] !== 1'b0) begin n_fail++; $display("FAIL abuse_no_setup cycle %0d got %b need 0", k, pready_v[0]); end
    end
    psel_v[0] = 1'b0; penable_v[0] = 1'b0;
    @(negedge pclk);
    n_tests++;
    if (regq_v[0] !== exp_q(0)) begin n_fail++; $display("FAIL abuse_no_setup_regs got %h need %h", regq_v[0], exp_q(0)); end
    // psel dropped during wait states on the three-wait instance
    psel_v[1] = 1'b1; penable_v[1] = 1'b0; paddr_v[1] = 32'hC; pwrite_v[1] = 1'b1; pwdata_v[1] = 32'hCAFE_F00D;
    @(negedge pclk);
    penable_v[1] = 1'b1;
    @(negedge pclk);
    psel_v[1] = 1'b0; penable_v[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge pclk);
      n_tests++;
      if (pready_v[1] !== 1'b0) begin n_fail++; $display("FAIL abort_pready cycle %0d got %b need 0", k, pready_v[1]); end
    end
    n_tests++;
    if (regq_v[1] !== exp_q(1)) begin n_fail++; $display("FAIL abort_regs got %h need %h", regq_v[1], exp_q(1)); end
    model_xfer(1, 1'b0, 32'h4, 32'h0, e_rd, e_err);
    xfer(1, 1'b0, 32'h4, 32'h0, rd, err, w, q);
    n_tests++;
    if (rd !== e_rd || w !== 3) begin n_fail++; $display("FAIL abort_recover got %h/%0d need %h/3", rd, w, e_rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, e_rd; logic err, e_err; int w; logic [NR*32-1:0] q;
    do_reset();
    model_xfer(1, 1'b0, 32'h0, 32'h0, e_rd, e_err);
    xfer(1, 1'b0, 32'h0, 32'h0, rd, err, w, q);
    psel_v[1] = 1'b1; penable_v[1] = 1'b0; paddr_v[1] = 32'h10; pwrite_v[1] = 1'b1; pwdata_v[1] = 32'h0BAD_CAFE;
    @(negedge pclk);
    penable_v[1] = 1'b1;
    @(negedge pclk);
    prst_n = 1'b0;
    #1;
    n_tests++;
    if (pready_v[1] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pready got %b need 0", pready_v[1]); end
    n_tests++;
    if (prdata_v[1] !== 32'h0) begin n_fail++; $display("FAIL rst_mid_prdata got %h need 0", prdata_v[1]); end
    n_tests++;
    if (pslverr_v[1] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pslverr got %b need 0", pslverr_v[1]); end
    psel_v[1] = 1'b0; penable_v[1] = 1'b0;
    @(negedge pclk);
    prst_n = 1'b1;
    model_reset();
    @(negedge pclk);
    n_tests++;
    if (regq_v[1][159:128] !== 32'h0) begin n_fail++; $display("FAIL rst_mid_target got %h need 0", regq_v[1][159:128]); end
    model_xfer(1, 1'b0, 32'h10, 32'h0, e_rd, e_err);
    xfer(1, 1'b0, 32'h10, 32'h0, rd, err, w, q);
    n_tests++;
    if (rd !== e_rd || err !== e_err || w !== 3) begin n_fail++; $display("FAIL rst_mid_recover got %h/%b/%0d need %h/%b/3", rd, err, w, e_rd, e_err); end
  endtask

  task automatic test_random();
    logic [31:0] rd, e_rd, a, wd; logic err, e_err, wr; int w, d, idx; logic [NR*32-1:0] q;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      d   = $urandom_range(0, 1);
      idx = $urandom_range(0, NR + 3);
      a   = 32'(idx * 4);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      model_xfer(d, wr, a, wd, e_rd, e_err);
      xfer(d, wr, a, wd, rd, err, w, q);
      n_tests++;
      if (err !== e_err) begin n_fail++; $display("FAIL rnd_pslverr n=%0d dut%0d addr=%h got %b need %b", n, d, a, err, e_err); end
      if (!wr) begin
        n_tests++;
        if (rd !== e_rd) begin n_fail++; $display("FAIL rnd_prdata n=%0d dut%0d addr=%h got %h need %h", n, d, a, rd, e_rd); end
      end
      n_tests++;
      if (w !== wait_of[d]) begin n_fail++; $display("FAIL rnd_wait n=%0d dut%0d got %0d need %0d", n, d, w, wait_of[d]); end
      n_tests++;
      if (regq_v[d] !== exp_q(d)) begin n_fail++; $display("FAIL rnd_reg_q n=%0d dut%0d got %h need %h", n, d, regq_v[d], exp_q(d)); end
      if ($urandom_range(0, 1) == 1) @(negedge pclk);
    end
  endtask

  initial begin
    psel_v = '0; penable_v = '0; pwrite_v = '0; paddr_v = '0; pwdata_v = '0;
    model_reset();
    test_reset();
    test_id_and_count();
    test_back_to_back();
    test_wait_states();
    test_errors();
    test_cnt_wrap();
    test_protocol_abuse();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
